// File: rtl/acq_mem_writer.sv
// Acquisition memory writer: streams a programmed number of AXI-Stream samples into the RAM write port.
// Latency: a sample accepted at cycle k is presented on wr_addr/wr_data/wr_en at k+1; done rises the cycle after the last write.
// Backpressure: one-deep output register; s_axis_tready = !wr_en || wr_ready while running, 0 otherwise.
//
// Ports:
//   clk, aresetn        clock, async active-low reset
//   clear               synchronous soft reset (priority over everything but aresetn)
//   start, nb_of_sample run request (rising edge) and word count latched on that edge
//   s_axis_*            sample input stream
//   wr_addr/data/en     RAM write request, held until wr_ready
//   busy, done, sts     status; sts = {done, busy, wrapped, written_count[28:0]}
module acq_mem_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clear,
  input  logic                  start,
  input  logic [31:0]           nb_of_sample,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           sts
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    start_q;
  logic [31:0]             target_q;
  logic [31:0]             acc_cnt_q;
  logic [28:0]             wr_cnt_q;
  logic [28:0]             wr_cnt_d;
  logic                    wrapped_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_en_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    start_rise;
  logic                    accept;
  logic                    wr_hs;
  logic                    last_acc;

  assign start_rise    = start && !start_q;
  // Output register can take a new word when empty or when it empties this cycle.
  assign s_axis_tready = (state_q == S_RUN) && (!wr_en_q || wr_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign wr_hs         = wr_en_q && wr_ready;
  // Only evaluated in RUN, where target_q is never zero.
  assign last_acc      = (acc_cnt_q == (target_q - 32'd1));
  // Progress count saturates rather than rolling over into the status flags.
  assign wr_cnt_d      = (&wr_cnt_q) ? wr_cnt_q : (wr_cnt_q + 29'd1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      start_q   <= start;   // a start held through reset is not an edge
      target_q  <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wrapped_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear) begin
      state_q   <= S_IDLE;
      start_q   <= start;
      target_q  <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wrapped_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;  // pending write is dropped
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      start_q <= start;

      if (wr_hs) begin
        wr_cnt_q  <= wr_cnt_d;
        wr_addr_q <= wr_addr_q + 1'b1;
        if (&wr_addr_q) begin
          wrapped_q <= 1'b1;
        end
        wr_en_q   <= 1'b0;
      end

      // A same-cycle acceptance refills the register, overriding the drop above.
      if (accept) begin
        wr_data_q <= s_axis_tdata;
        wr_en_q   <= 1'b1;
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          // wr_en is always low here, so no handshake competes with these clears.
          if (start_rise) begin
            target_q  <= nb_of_sample;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wrapped_q <= 1'b0;
            wr_addr_q <= '0;
            if (nb_of_sample == 32'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept && last_acc) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (wr_hs) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sts     = {done_q, busy_q, wrapped_q, wr_cnt_q};

endmodule
